// File: rtl/commit_unit.sv
// ROB commit consumer: retires up to two slots per cycle into the retirement RAT,
// returns superseded physical tags, and on an exception flushes then streams the RRAT to rename.
module commit_unit #(
  parameter int ISSUE_W   = 2,
  parameter int ARCH_REGS = 32,
  parameter int PREG_W    = 7,   // $clog2(core_pkg::PREGS)
  parameter int ROB_SIZE  = 32,  // core_pkg::ROB_ENTRIES
  parameter int ZERO_REG  = 31,
  localparam int PTR_W    = $clog2(ROB_SIZE)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ISSUE_W-1:0]    commit_valid,
  input  logic [2*5-1:0]        commit_arch_rd,
  input  logic [2*PREG_W-1:0]   commit_phys_rd,
  input  logic [ISSUE_W-1:0]    commit_exception,
  output logic [ISSUE_W-1:0]    free_valid,
  output logic [2*PREG_W-1:0]   free_preg,
  output logic                  flush_en,
  output logic [PTR_W-1:0]      flush_ptr,
  output logic                  freelist_reset,
  output logic                  restore_valid,
  output logic [4:0]            restore_idx,
  output logic [2*PREG_W-1:0]   restore_preg,
  output logic                  restore_done,
  output logic                  busy,
  output logic [31:0]           retired_count
);

  typedef enum logic [1:0] {IDLE, FLUSH, RESTORE} state_t;

  localparam logic [3:0] LAST_BEAT = 4'(ARCH_REGS / 2 - 1);
  localparam logic [4:0] ZREG      = 5'(ZERO_REG);

  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] ptr,
                                               input logic [1:0]       n);
    logic [PTR_W:0] sum;
    sum = {1'b0, ptr} + (PTR_W+1)'(n);
    if (sum >= (PTR_W+1)'(ROB_SIZE))
      sum = sum - (PTR_W+1)'(ROB_SIZE);
    return sum[PTR_W-1:0];
  endfunction

  state_t                state_q, state_d;
  logic [3:0]            beat_q, beat_d;
  logic [PREG_W-1:0]     rrat_q [ARCH_REGS];
  logic [PREG_W-1:0]     rrat_d [ARCH_REGS];
  logic [PTR_W-1:0]      head_ptr_q, head_ptr_d;
  logic [31:0]           retired_count_q, retired_count_d;
  logic [ISSUE_W-1:0]    free_valid_q, free_valid_d;
  logic [2*PREG_W-1:0]   free_preg_q, free_preg_d;
  logic                  flush_en_q, flush_en_d;
  logic [PTR_W-1:0]      flush_ptr_q, flush_ptr_d;
  logic                  freelist_reset_q, freelist_reset_d;
  logic                  restore_valid_q, restore_valid_d;
  logic [4:0]            restore_idx_q, restore_idx_d;
  logic [2*PREG_W-1:0]   restore_preg_q, restore_preg_d;
  logic                  restore_done_q, restore_done_d;
  logic                  busy_q, busy_d;

  logic [4:0]            arch0, arch1;
  logic [PREG_W-1:0]     phys0, phys1;
  logic                  ret0, ret1, exc0, exc1, exc_any;
  logic [1:0]            n_ret, n_consumed;
  logic [PREG_W-1:0]     free0, free1;
  logic                  emit_beat;

  assign arch0 = commit_arch_rd[4:0];
  assign arch1 = commit_arch_rd[9:5];
  assign phys0 = commit_phys_rd[PREG_W-1:0];
  assign phys1 = commit_phys_rd[2*PREG_W-1:PREG_W];

  // An excepting slot0 squashes slot1; an excepting slot still consumes its ROB entry.
  assign exc0       = commit_valid[0] & commit_exception[0];
  assign exc1       = commit_valid[1] & commit_exception[1];
  assign ret0       = commit_valid[0] & ~commit_exception[0];
  assign ret1       = commit_valid[1] & ~commit_exception[1] & ~exc0;
  assign exc_any    = exc0 | exc1;
  assign n_ret      = {1'b0, ret0} + {1'b0, ret1};
  assign n_consumed = n_ret + {1'b0, exc_any};

  // Slot1 aliasing slot0's destination must free slot0's fresh tag, not the stale map.
  assign free0 = (arch0 == ZREG) ? phys0 : rrat_q[arch0];
  assign free1 = (arch1 == ZREG)                 ? phys1 :
                 (ret0 && (arch0 == arch1))      ? phys0 : rrat_q[arch1];

  always_comb begin
    state_d          = state_q;
    beat_d           = beat_q;
    rrat_d           = rrat_q;
    head_ptr_d       = head_ptr_q;
    retired_count_d  = retired_count_q;
    free_valid_d     = '0;
    free_preg_d      = free_preg_q;
    flush_en_d       = 1'b0;
    flush_ptr_d      = flush_ptr_q;
    freelist_reset_d = 1'b0;
    restore_valid_d  = 1'b0;
    restore_idx_d    = restore_idx_q;
    restore_preg_d   = restore_preg_q;
    restore_done_d   = 1'b0;
    emit_beat        = 1'b0;

    case (state_q)
      IDLE: begin
        if (ret0) begin
          free_preg_d[PREG_W-1:0] = free0;
          if (arch0 != ZREG) rrat_d[arch0] = phys0;
        end
        if (ret1) begin
          free_preg_d[2*PREG_W-1:PREG_W] = free1;
          if (arch1 != ZREG) rrat_d[arch1] = phys1;
        end
        free_valid_d    = {ret1, ret0};
        head_ptr_d      = ptr_add(head_ptr_q, n_consumed);
        retired_count_d = retired_count_q + 32'(n_ret);
        if (exc_any) begin
          state_d          = FLUSH;
          flush_en_d       = 1'b1;
          freelist_reset_d = 1'b1;
          flush_ptr_d      = head_ptr_d;
        end
      end
      FLUSH: begin
        state_d   = RESTORE;
        beat_d    = '0;
        emit_beat = 1'b1;
      end
      RESTORE: begin
        if (beat_q == LAST_BEAT) begin
          state_d = IDLE;
        end else begin
          beat_d    = beat_q + 4'd1;
          emit_beat = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (emit_beat) begin
      restore_valid_d = 1'b1;
      restore_idx_d   = {beat_d, 1'b0};
      restore_preg_d  = {rrat_q[{beat_d, 1'b1}], rrat_q[{beat_d, 1'b0}]};
      restore_done_d  = (beat_d == LAST_BEAT);
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      beat_q           <= '0;
      for (int i = 0; i < ARCH_REGS; i++) rrat_q[i] <= PREG_W'(i);
      head_ptr_q       <= '0;
      retired_count_q  <= '0;
      free_valid_q     <= '0;
      free_preg_q      <= '0;
      flush_en_q       <= 1'b0;
      flush_ptr_q      <= '0;
      freelist_reset_q <= 1'b0;
      restore_valid_q  <= 1'b0;
      restore_idx_q    <= '0;
      restore_preg_q   <= '0;
      restore_done_q   <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      beat_q           <= beat_d;
      rrat_q           <= rrat_d;
      head_ptr_q       <= head_ptr_d;
      retired_count_q  <= retired_count_d;
      free_valid_q     <= free_valid_d;
      free_preg_q      <= free_preg_d;
      flush_en_q       <= flush_en_d;
      flush_ptr_q      <= flush_ptr_d;
      freelist_reset_q <= freelist_reset_d;
      restore_valid_q  <= restore_valid_d;
      restore_idx_q    <= restore_idx_d;
      restore_preg_q   <= restore_preg_d;
      restore_done_q   <= restore_done_d;
      busy_q           <= busy_d;
    end
  end

  assign free_valid     = free_valid_q;
  assign free_preg      = free_preg_q;
  assign flush_en       = flush_en_q;
  assign flush_ptr      = flush_ptr_q;
  assign freelist_reset = freelist_reset_q;
  assign restore_valid  = restore_valid_q;
  assign restore_idx    = restore_idx_q;
  assign restore_preg   = restore_preg_q;
  assign restore_done   = restore_done_q;
  assign busy           = busy_q;
  assign retired_count  = retired_count_q;

  // Slot1 valid without slot0 breaks the ROB's in-order commit contract.
  a_slot1_alone: assert property (@(posedge clk) disable iff (reset)
    !(state_q == IDLE && commit_valid == 2'b10));

endmodule

// File: tb/tb_commit_unit.sv
// Scoreboard bench for commit_unit: directed commits push expected free/flush/restore
// events into queues; a negedge monitor pops and compares whenever the DUT presents one.
module tb_commit_unit;

  localparam int PW  = 7;
  localparam int ROB = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [1:0]      commit_valid;
  logic [9:0]      commit_arch_rd;
  logic [2*PW-1:0] commit_phys_rd;
  logic [1:0]      commit_exception;
  logic [1:0]      free_valid;
  logic [2*PW-1:0] free_preg;
  logic            flush_en;
  logic [4:0]      flush_ptr;
  logic            freelist_reset;
  logic            restore_valid;
  logic [4:0]      restore_idx;
  logic [2*PW-1:0] restore_preg;
  logic            restore_done;
  logic            busy;
  logic [31:0]     retired_count;

  commit_unit #(.PREG_W(PW), .ROB_SIZE(ROB)) dut (
    .clk(clk), .reset(reset),
    .commit_valid(commit_valid), .commit_arch_rd(commit_arch_rd),
    .commit_phys_rd(commit_phys_rd), .commit_exception(commit_exception),
    .free_valid(free_valid), .free_preg(free_preg),
    .flush_en(flush_en), .flush_ptr(flush_ptr), .freelist_reset(freelist_reset),
    .restore_valid(restore_valid), .restore_idx(restore_idx),
    .restore_preg(restore_preg), .restore_done(restore_done),
    .busy(busy), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [1:0] fv; logic [PW-1:0] f0; logic [PW-1:0] f1; } free_t;
  typedef struct { logic [4:0] idx; logic [PW-1:0] p0; logic [PW-1:0] p1; logic done; } beat_t;

  free_t      free_q[$];
  int         flush_q[$];
  beat_t      beat_q[$];
  logic [PW-1:0] mdl_rrat [32];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare each presented DUT event against the head of its queue.
  always @(negedge clk) begin
    if (!reset) begin
      if (free_valid != 2'b00) begin
        if (free_q.size() == 0) chk("free_unexpected", free_valid, 0);
        else begin
          free_t e;
          e = free_q.pop_front();
          chk("free_valid", free_valid, e.fv);
          if (e.fv[0]) chk("free_preg0", free_preg[PW-1:0], e.f0);
          if (e.fv[1]) chk("free_preg1", free_preg[2*PW-1:PW], e.f1);
        end
      end
      if (flush_en) begin
        if (flush_q.size() == 0) chk("flush_unexpected", flush_en, 0);
        else begin
          int p;
          p = flush_q.pop_front();
          chk("flush_ptr", flush_ptr, p);
          chk("freelist_reset", freelist_reset, 1);
          chk("busy_in_flush", busy, 1);
        end
      end else if (freelist_reset) chk("freelist_reset_alone", freelist_reset, 0);
      if (restore_valid) begin
        if (beat_q.size() == 0) chk("restore_unexpected", restore_valid, 0);
        else begin
          beat_t b;
          b = beat_q.pop_front();
          chk("restore_idx", restore_idx, b.idx);
          chk("restore_preg_lo", restore_preg[PW-1:0], b.p0);
          chk("restore_preg_hi", restore_preg[2*PW-1:PW], b.p1);
          chk("restore_done", restore_done, b.done);
          chk("busy_in_restore", busy, 1);
        end
      end else if (restore_done) chk("restore_done_alone", restore_done, 0);
    end
  end

  task automatic push_stream();
    for (int k = 0; k < 16; k++) begin
      beat_t b;
      b.idx = 5'(2*k);
      b.p0 = mdl_rrat[2*k];
      b.p1 = mdl_rrat[2*k+1];
      b.done = (k == 15);
      beat_q.push_back(b);
    end
  endtask

  task automatic idle_inputs();
    commit_valid = 2'b00; commit_exception = 2'b00;
    commit_arch_rd = '0; commit_phys_rd = '0;
  endtask

  // Drives one commit cycle. efv/ef0/ef1 are the hand-computed frees; eptr>=0 expects a flush.
  task automatic do_commit(input logic [1:0] v, input logic [1:0] e,
                           input logic [4:0] a0, input logic [PW-1:0] p0,
                           input logic [4:0] a1, input logic [PW-1:0] p1,
                           input logic [1:0] efv, input logic [PW-1:0] ef0,
                           input logic [PW-1:0] ef1, input int eptr);
    free_t f;
    if (efv != 2'b00) begin
      f.fv = efv; f.f0 = ef0; f.f1 = ef1;
      free_q.push_back(f);
    end
    if (efv[0] && a0 != 5'd31) mdl_rrat[a0] = p0;
    if (efv[1] && a1 != 5'd31) mdl_rrat[a1] = p1;
    if (eptr >= 0) begin
      flush_q.push_back(eptr);
      push_stream();
    end
    commit_valid = v; commit_exception = e;
    commit_arch_rd = {a1, a0}; commit_phys_rd = {p1, p0};
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic wait_stream_end();
    int n;
    n = 0;
    while (!restore_done && n < 60) begin
      @(posedge clk); #2;
      n++;
    end
    chk("restore_done_seen", (n < 60), 1);
    @(posedge clk); #2;
    chk("busy_after_restore", busy, 0);
    chk("sb_drained", free_q.size() + flush_q.size() + beat_q.size(), 0);
  endtask

  task automatic check_all_zero();
    chk("rst_free_valid", free_valid, 0);
    chk("rst_free_preg", free_preg, 0);
    chk("rst_flush_en", flush_en, 0);
    chk("rst_flush_ptr", flush_ptr, 0);
    chk("rst_freelist_reset", freelist_reset, 0);
    chk("rst_restore_valid", restore_valid, 0);
    chk("rst_restore_idx", restore_idx, 0);
    chk("rst_restore_preg", restore_preg, 0);
    chk("rst_restore_done", restore_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_retired_count", retired_count, 0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mdl_rrat[i] = PW'(i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero();
    reset = 1'b0;
    @(posedge clk); #1;

    // Identity stream via an exception on slot0 at head 0.
    do_commit(2'b01, 2'b01, 5'd1, 7'd99, 5'd0, 7'd0, 2'b00, 0, 0, 1);
    wait_stream_end();
    chk("count_after_exc0", retired_count, 0);

    @(posedge clk); #1;
    do_commit(2'b01, 2'b00, 5'd3, 7'd40, 5'd0, 7'd0, 2'b01, 7'd3, 0, -1);
    @(posedge clk); #1;
    chk("count_single", retired_count, 1);
    do_commit(2'b11, 2'b00, 5'd5, 7'd41, 5'd5, 7'd42, 2'b11, 7'd5, 7'd41, -1);
    do_commit(2'b01, 2'b00, 5'd31, 7'd50, 5'd0, 7'd0, 2'b01, 7'd50, 0, -1);
    do_commit(2'b11, 2'b00, 5'd8, 7'd45, 5'd9, 7'd46, 2'b11, 7'd8, 7'd9, -1);
    @(posedge clk); #1;
    do_commit(2'b11, 2'b00, 5'd8, 7'd47, 5'd31, 7'd51, 2'b11, 7'd45, 7'd51, -1);
    do_commit(2'b01, 2'b00, 5'd10, 7'd48, 5'd0, 7'd0, 2'b01, 7'd10, 0, -1);
    @(posedge clk); #1;
    chk("count_before_exc1", retired_count, 9);

    // Slot1 excepts at head 10: slot0 retires, flush to 12; commits during recovery are dropped.
    do_commit(2'b11, 2'b10, 5'd7, 7'd44, 5'd12, 7'd52, 2'b01, 7'd7, 0, 12);
    commit_valid = 2'b11; commit_exception = 2'b00;
    commit_arch_rd = {5'd4, 5'd3}; commit_phys_rd = {7'd98, 7'd99};
    repeat (3) @(posedge clk);
    #1;
    idle_inputs();
    wait_stream_end();
    chk("count_after_exc1", retired_count, 10);

    // Walk head from 12 to 31 through XZR commits, then wrap with a dual retire.
    for (int i = 0; i < 9; i++)
      do_commit(2'b11, 2'b00, 5'd31, 7'(60+2*i), 5'd31, 7'(61+2*i),
                2'b11, 7'(60+2*i), 7'(61+2*i), -1);
    do_commit(2'b01, 2'b00, 5'd31, 7'd80, 5'd0, 7'd0, 2'b01, 7'd80, 0, -1);
    do_commit(2'b11, 2'b00, 5'd31, 7'd81, 5'd31, 7'd82, 2'b11, 7'd81, 7'd82, -1);
    @(posedge clk); #1;
    chk("count_after_wrap", retired_count, 31);
    do_commit(2'b01, 2'b01, 5'd2, 7'd90, 5'd0, 7'd0, 2'b00, 0, 0, 2);

    // Reset lands during restore beat 5.
    n = 0;
    while (!(restore_valid && restore_idx == 5'd10) && n < 30) begin
      @(posedge clk); #2;
      n++;
    end
    chk("beat5_seen", (n < 30), 1);
    #4;
    reset = 1'b1;
    #1;
    check_all_zero();
    beat_q.delete();
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check_all_zero();

    // Slot0 exception discards a valid slot1; stream must be the identity map again.
    do_commit(2'b11, 2'b01, 5'd6, 7'd91, 5'd4, 7'd92, 2'b00, 0, 0, 1);
    wait_stream_end();
    chk("count_after_reset", retired_count, 0);

    repeat (3) @(posedge clk);
    chk("sb_final", free_q.size() + flush_q.size() + beat_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
